// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 16x32 register memory (fp, sp, r0-r13).
// Two writeback sources (port 0 = ALU, port 1 = load) each feed a
// 1-entry holding register. One held entry is granted per cycle, oldest
// first, into a registered output stage that drives the memory write port.
// A combinational hazard lookup reports in-flight writes to the read side.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   wb_valid_i     per-port write request valid
//   wb_ready_o     per-port accept (comb.); transfer when valid & ready
//   wb_addr_i      per-port address, port p at [p*ADDR_W +: ADDR_W]
//   wb_data_i      per-port data,    port p at [p*DATA_W +: DATA_W]
//   mem_we_o       memory write enable (registered)
//   mem_addr_o     memory write address (registered)
//   mem_data_o     memory write data (registered)
//   hz_addr_i      register address being read this cycle
//   hz_pending_o   a write to hz_addr_i is in flight (comb.)
//   hz_data_o      youngest in-flight value for hz_addr_i, 0 if none (comb.)
//   idle_o         holding registers and output stage all empty (comb.)
module regfile_wr_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            wb_valid_i,
  output logic [1:0]            wb_ready_o,
  input  logic [2*ADDR_W-1:0]   wb_addr_i,
  input  logic [2*DATA_W-1:0]   wb_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_data_o,
  input  logic [ADDR_W-1:0]     hz_addr_i,
  output logic                  hz_pending_o,
  output logic [DATA_W-1:0]     hz_data_o,
  output logic                  idle_o
);

  logic [1:0]        held;
  logic [ADDR_W-1:0] h_addr [2];
  logic [DATA_W-1:0] h_data [2];
  logic              older_vld;   // older is meaningful (both entries held)
  logic              older;       // port index of the older held entry
  logic              rr;          // fairness pointer, flips on every both-held grant

  logic [1:0]        grant;
  logic              sel;
  logic [1:0]        acc;
  logic [1:0]        keep;
  logic [1:0]        held_n;

  // Grant: a lone held entry wins; with two held, the older one wins.
  always_comb begin
    grant = held;
    sel   = 1'b0;
    if (held == 2'b11) begin
      sel   = older_vld ? older : rr;
      grant = sel ? 2'b10 : 2'b01;
    end
  end

  assign wb_ready_o = ~held | grant;
  assign acc        = wb_valid_i & wb_ready_o;
  // An entry that stays held is one that was not granted (so not replaced).
  assign keep       = held & ~grant;
  assign held_n     = acc | keep;

  // Holding registers, age tracking and output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held       <= 2'b00;
      older_vld  <= 1'b0;
      older      <= 1'b0;
      rr         <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      for (int p = 0; p < 2; p++) begin
        h_addr[p] <= '0;
        h_data[p] <= '0;
      end
    end else begin
      held <= held_n;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          h_addr[p] <= wb_addr_i[p*ADDR_W +: ADDR_W];
          h_data[p] <= wb_data_i[p*DATA_W +: DATA_W];
        end
      end
      // A surviving entry is always older than a freshly accepted one;
      // two fresh entries from the same edge leave port 0 as the older.
      older_vld <= &held_n;
      older     <= keep[1];
      if (held == 2'b11) begin
        rr <= ~rr;
      end
      if (|grant) begin
        mem_we_o   <= 1'b1;
        mem_addr_o <= grant[1] ? h_addr[1] : h_addr[0];
        mem_data_o <= grant[1] ? h_data[1] : h_data[0];
      end else begin
        mem_we_o <= 1'b0;
      end
    end
  end

  logic m0, m1, mo;

  // Hazard lookup: younger held > older held > output stage.
  always_comb begin
    m0           = held[0] && (h_addr[0] == hz_addr_i);
    m1           = held[1] && (h_addr[1] == hz_addr_i);
    mo           = mem_we_o && (mem_addr_o == hz_addr_i);
    hz_pending_o = m0 | m1 | mo;
    hz_data_o    = '0;
    if (m0 && m1) begin
      hz_data_o = older ? h_data[0] : h_data[1];
    end else if (m0) begin
      hz_data_o = h_data[0];
    end else if (m1) begin
      hz_data_o = h_data[1];
    end else if (mo) begin
      hz_data_o = mem_data_o;
    end
  end

  assign idle_o = ~held[0] & ~held[1] & ~mem_we_o;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter. Every accepted write is queued
// with the cycle it must appear at the memory (in order, one per cycle, no
// earlier than one cycle after it was held). The queue also answers the
// expected ready, idle and hazard outputs each cycle.
module tb_regfile_wr_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      wb_valid = 2'b00;
  logic [1:0]      wb_ready;
  logic [2*AW-1:0] wb_addr = '0;
  logic [2*DW-1:0] wb_data = '0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic [AW-1:0]   hz_addr = '0;
  logic            hz_pending;
  logic [DW-1:0]   hz_data;
  logic            idle;

  regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .hz_addr_i(hz_addr), .hz_pending_o(hz_pending), .hz_data_o(hz_data),
    .idle_o(idle)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            port;
    int            acc;
    int            due;
  } ent_t;

  typedef struct {
    logic          idle;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  ent_t          fl[$];          // accepted writes not yet seen at the memory
  item_t         src[2][$];      // per-port stimulus
  int            cyc = 0;
  int            last_due = 0;
  logic [1:0]    acc_stash = 2'b00;
  logic [DW-1:0] dmem [16];
  int            hz_force = -1;
  int            n_chk = 0;
  int            n_pass = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Reference model: record accepts in order and give each its write cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fl.delete();
      last_due = cyc;
    end else begin
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (acc_stash[p]) begin
          ent_t e;
          e.addr = wb_addr[p*AW +: AW];
          e.data = wb_data[p*DW +: DW];
          e.port = p;
          e.acc  = cyc;
          e.due  = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
          last_due = e.due;
          fl.push_back(e);
        end
      end
    end
  end

  logic [1:0]    exp_rdy;
  logic          exp_pend;
  logic [DW-1:0] exp_hd;
  logic          exp_we;

  // Monitor: compare outputs against the model away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      acc_stash = 2'b00;
    end else begin
      exp_rdy  = 2'b11;
      exp_pend = 1'b0;
      exp_hd   = '0;
      foreach (fl[i]) begin
        if (cyc < fl[i].due - 1) exp_rdy[fl[i].port] = 1'b0;
        if (fl[i].addr == hz_addr) begin
          exp_pend = 1'b1;
          exp_hd   = fl[i].data;
        end
      end
      chk("ready", wb_ready, exp_rdy);
      chk("idle", idle, fl.size() == 0);
      chk("hz_pending", hz_pending, exp_pend);
      chk("hz_data", hz_data, exp_hd);
      exp_we = (fl.size() > 0) && (fl[0].due == cyc);
      chk("mem_we", mem_we, exp_we);
      if (mem_we) dmem[mem_addr] = mem_data;
      if (mem_we && exp_we) begin
        chk("mem_addr", mem_addr, fl[0].addr);
        chk("mem_data", mem_data, fl[0].data);
      end
      if (fl.size() > 0 && fl[0].due <= cyc) void'(fl.pop_front());
      acc_stash = wb_valid & wb_ready;
    end
  end

  function automatic item_t mk(input int a, input logic [DW-1:0] d);
    item_t it;
    it.idle = 1'b0;
    it.addr = AW'(a);
    it.data = d;
    return it;
  endfunction

  function automatic item_t gap();
    item_t it;
    it.idle = 1'b1;
    it.addr = '0;
    it.data = '0;
    return it;
  endfunction

  // Drive both port queues, holding valid until accepted, then drain.
  task automatic run_queues(input int budget);
    int n = 0;
    while ((src[0].size() > 0 || src[1].size() > 0 || wb_valid != 2'b00) && n < budget) begin
      @(posedge clock);
      #1;
      n++;
      for (int p = 0; p < 2; p++) begin
        if (acc_stash[p]) wb_valid[p] = 1'b0;
        if (!wb_valid[p] && src[p].size() > 0) begin
          item_t it;
          it = src[p].pop_front();
          if (!it.idle) begin
            wb_valid[p] = 1'b1;
            wb_addr[p*AW +: AW] = it.addr;
            wb_data[p*DW +: DW] = it.data;
          end
        end
      end
      if (hz_force >= 0) hz_addr = AW'(hz_force);
      else if ($urandom_range(0, 1) == 1) hz_addr = wb_addr[$urandom_range(0, 1)*AW +: AW];
      else hz_addr = AW'($urandom_range(0, 15));
    end
    if (n >= budget) chk("stimulus_timeout", 1, 0);
    for (int i = 0; i < 20 && fl.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    chk("drain", fl.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    #12;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_ready", wb_ready, 2'b11);
    chk("rst_idle", idle, 1);
    chk("rst_pend", hz_pending, 0);
    @(negedge clock);
    #1 reset = 1'b0;

    // Single write: port 0 addr 2.
    src[0].push_back(mk(2, 32'hDEADBEEF));
    run_queues(50);

    // Hazard on a held address, then a non-matching address.
    hz_force = 3;
    src[0].push_back(mk(3, 32'h000000A5));
    run_queues(50);
    hz_force = 4;
    src[0].push_back(mk(3, 32'h000000A5));
    run_queues(50);
    hz_force = -1;

    // Same-address ordering: port 1 first, port 0 one cycle later.
    hz_force = 5;
    src[1].push_back(mk(5, 32'h11));
    src[0].push_back(gap());
    src[0].push_back(mk(5, 32'h22));
    run_queues(50);
    chk("mem5_final", dmem[5], 32'h22);
    hz_force = -1;

    // Contention: both ports streaming, distinct addresses.
    for (int i = 0; i < 8; i++) begin
      src[0].push_back(mk(i, 32'hA000_0000 + 32'(i)));
      src[1].push_back(mk(i + 8, 32'hB000_0000 + 32'(i)));
    end
    run_queues(100);

    // Backpressure: port 1 streams while port 0 keeps an older entry.
    src[0].push_back(mk(9, 32'h0909));
    for (int i = 0; i < 10; i++) begin
      src[1].push_back(mk(i, 32'hC000_0000 + 32'(i)));
      src[0].push_back(mk(15 - i, 32'hD000_0000 + 32'(i)));
    end
    run_queues(100);

    // Reset mid-stream: write must drop at once, nothing stray afterwards.
    for (int i = 0; i < 6; i++) begin
      src[0].push_back(mk(i, 32'(i)));
      src[1].push_back(mk(i + 6, 32'(i + 100)));
    end
    fork
      run_queues(40);
      begin
        repeat (4) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_ready", wb_ready, 2'b11);
        chk("midrst_idle", idle, 1);
        chk("midrst_pend", hz_pending, 0);
        src[0].delete();
        src[1].delete();
        wb_valid = 2'b00;
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
      end
    join
    repeat (5) @(posedge clock);

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) == 0) src[p].push_back(gap());
        src[p].push_back(mk(int'($urandom_range(0, 15)), $urandom));
      end
    end
    run_queues(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
